// File: rtl/unum4_fpu_arbiter_pkg.sv
// Shared constants for the unum4 FPU arbiter: opcode width and encodings,
// FSM state encoding and response flag bit positions.
package unum4_fpu_arbiter_pkg;

    localparam int unsigned OPCODE_W = 2;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_DIV = 2'b10,
        OP_MUL = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_CAPT = 2'b10,
        ST_RESP = 2'b11
    } state_e;

    // Response flag vector layout: {timeout, div_by_zero, underflow, overflow}
    localparam int unsigned FLAGS_W  = 4;
    localparam int unsigned FLAG_OVF = 0;
    localparam int unsigned FLAG_UNF = 1;
    localparam int unsigned FLAG_DBZ = 2;
    localparam int unsigned FLAG_TMO = 3;

endpackage

// File: rtl/unum4_fpu_arbiter_if.sv
// Requester bus and FPU bus of the unum4 FPU arbiter.
// slave  : the arbiter's view; master : the requesters/FPU environment view.
interface unum4_fpu_arbiter_if
    import unum4_fpu_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_REQ  = 4
);

    // requester side
    logic [N_REQ-1:0]          req;
    logic [N_REQ*DATA_W-1:0]   a_in;
    logic [N_REQ*DATA_W-1:0]   b_in;
    logic [N_REQ*OPCODE_W-1:0] op_in;
    logic [N_REQ-1:0]          ack;
    logic [N_REQ-1:0]          resp_valid;
    logic [DATA_W-1:0]         result;
    logic [FLAGS_W-1:0]        flags;
    logic                      busy;

    // FPU side
    logic                      fpu_start;
    logic [DATA_W-1:0]         fpu_a;
    logic [DATA_W-1:0]         fpu_b;
    logic [OPCODE_W-1:0]       fpu_op;
    logic [DATA_W-1:0]         fpu_o;
    logic                      fpu_overflow;
    logic                      fpu_underflow;
    logic                      fpu_div_by_zero;
    logic                      fpu_done;

    modport slave (
        input  req, a_in, b_in, op_in,
        output ack, resp_valid, result, flags, busy,
        output fpu_start, fpu_a, fpu_b, fpu_op,
        input  fpu_o, fpu_overflow, fpu_underflow, fpu_div_by_zero, fpu_done
    );

    modport master (
        output req, a_in, b_in, op_in,
        input  ack, resp_valid, result, flags, busy,
        input  fpu_start, fpu_a, fpu_b, fpu_op,
        output fpu_o, fpu_overflow, fpu_underflow, fpu_div_by_zero, fpu_done
    );

endinterface

// File: rtl/unum4_fpu_arbiter_rr_pick.sv
// Round-robin priority picker: grants the first active request at or after
// (last_grant + 1) mod N_REQ. Purely combinational.
module unum4_rr_pick #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0] grant,
    output logic             valid
);

    logic             found;
    logic [IDX_W-1:0] idx;

    // Scan requesters starting just after the last winner, wrapping around
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = IDX_W'((32'(last_grant) + k) % N_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        valid = found;
    end

endmodule

// File: rtl/unum4_fpu_arbiter.sv
// unum4 FPU arbiter: shares one multi-cycle FPU between N_REQ requesters
// with round-robin arbitration (IDLE -> RUN -> CAPT -> RESP).
// Optional watchdog on the RUN state: define UNUM4_ARB_TIMEOUT_EN.
module unum4_fpu_arbiter
    import unum4_fpu_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned EXP_SZ_W    = 4,
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input logic                clk,
    input logic                rst,
    unum4_fpu_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("unum4_fpu_arbiter: N_REQ must be in 2..8");
    end
    if (EXP_SZ_W == 0 || EXP_SZ_W >= DATA_W) begin : g_bad_exp_sz
        $error("unum4_fpu_arbiter: EXP_SZ_W must be in 1..DATA_W-1");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("unum4_fpu_arbiter: TIMEOUT_CYC must be at least 2");
    end

    state_e              state;
    state_e              state_nxt;

    logic [N_REQ-1:0]    pick_grant;
    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic [OPCODE_W-1:0] sel_op;

    logic [IDX_W-1:0]    last_grant;
    logic [IDX_W-1:0]    grant_idx;
    logic [N_REQ-1:0]    grant_oh;

    logic [N_REQ-1:0]    ack_q;
    logic [N_REQ-1:0]    resp_valid_q;
    logic                fpu_start_q;
    logic [DATA_W-1:0]   fpu_a_q;
    logic [DATA_W-1:0]   fpu_b_q;
    logic [OPCODE_W-1:0] fpu_op_q;
    logic [DATA_W-1:0]   result_q;
    logic [FLAG_TMO-1:0] flags_q;
    logic [FLAG_TMO-1:0] fpu_flags;
    logic [FLAGS_W-1:0]  flags_out;

    logic                timeout_hit;
    logic                tmo_flag;

    unum4_rr_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .req       (bus.req),
        .last_grant(last_grant),
        .grant     (pick_grant),
        .valid     (pick_valid)
    );

    // Winner index and its operand slices
    always_comb begin
        pick_idx = '0;
        sel_a    = '0;
        sel_b    = '0;
        sel_op   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_grant[i]) begin
                pick_idx = IDX_W'(i);
                sel_a    = bus.a_in[i*DATA_W +: DATA_W];
                sel_b    = bus.b_in[i*DATA_W +: DATA_W];
                sel_op   = bus.op_in[i*OPCODE_W +: OPCODE_W];
            end
        end
    end

    // One-hot form of the requester currently being served
    always_comb begin
        grant_oh = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            grant_oh[i] = (grant_idx == IDX_W'(i));
        end
    end

    // Sticky FPU exception inputs, mapped onto the flag layout
    always_comb begin
        fpu_flags           = '0;
        fpu_flags[FLAG_OVF] = bus.fpu_overflow;
        fpu_flags[FLAG_UNF] = bus.fpu_underflow;
        fpu_flags[FLAG_DBZ] = bus.fpu_div_by_zero;
    end

`ifdef UNUM4_ARB_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_q;
    logic            tmo_q;

    // Fires on the TIMEOUT_CYC-th RUN cycle that still has no fpu_done
    assign timeout_hit = (state == ST_RUN) && !bus.fpu_done &&
                         (wd_q == WD_W'(TIMEOUT_CYC - 1));
    assign tmo_flag    = tmo_q;

    // Watchdog: counts RUN cycles, cleared whenever a new operation starts
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q  <= '0;
            tmo_q <= 1'b0;
        end else if (state == ST_IDLE && pick_valid) begin
            wd_q  <= '0;
            tmo_q <= 1'b0;
        end else if (state == ST_RUN && !bus.fpu_done) begin
            wd_q <= wd_q + 1'b1;
            if (timeout_hit) begin
                tmo_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign tmo_flag    = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (pick_valid) state_nxt = ST_RUN;
            ST_RUN: begin
                if (bus.fpu_done) begin
                    state_nxt = ST_CAPT;
                end else if (timeout_hit) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_CAPT: state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: grant latch, FPU drive, flag accumulation, result capture,
    // and the registered ack/resp_valid pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant   <= IDX_W'(N_REQ - 1);
            grant_idx    <= '0;
            ack_q        <= '0;
            resp_valid_q <= '0;
            fpu_start_q  <= 1'b0;
            fpu_a_q      <= '0;
            fpu_b_q      <= '0;
            fpu_op_q     <= '0;
            result_q     <= '0;
            flags_q      <= '0;
        end else begin
            ack_q        <= '0;
            resp_valid_q <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_idx   <= pick_idx;
                        ack_q       <= pick_grant;
                        fpu_start_q <= 1'b1;
                        fpu_a_q     <= sel_a;
                        fpu_b_q     <= sel_b;
                        fpu_op_q    <= sel_op;
                        flags_q     <= '0;
                    end
                end
                ST_RUN: begin
                    flags_q <= flags_q | fpu_flags;
                    if (bus.fpu_done || timeout_hit) begin
                        fpu_start_q <= 1'b0;
                    end
                    if (timeout_hit) begin
                        result_q <= '0;
                    end
                end
                ST_CAPT: begin
                    result_q <= bus.fpu_o;
                end
                ST_RESP: begin
                    resp_valid_q <= grant_oh;
                    last_grant   <= grant_idx;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        flags_out                     = '0;
        flags_out[FLAG_TMO-1:0]       = flags_q;
        flags_out[FLAG_TMO]           = tmo_flag;
    end

    assign bus.ack        = ack_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.result     = result_q;
    assign bus.flags      = flags_out;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.fpu_start  = fpu_start_q;
    assign bus.fpu_a      = fpu_a_q;
    assign bus.fpu_b      = fpu_b_q;
    assign bus.fpu_op     = fpu_op_q;

endmodule

// File: tb/tb_unum4_fpu_arbiter.sv
// Scoreboard bench for unum4_fpu_arbiter with a behavioural FPU stub
// (done 6 cycles after start, o = a + b valid the cycle after done).
// Build with UNUM4_ARB_TIMEOUT_EN defined to exercise the watchdog.
module tb_unum4_fpu_arbiter;
    import unum4_fpu_arbiter_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 4;
    localparam int unsigned TO = 20;

    typedef struct {
        int         idx;
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    unum4_fpu_arbiter_if #(.DATA_W(DW), .N_REQ(NR)) bus ();

    unum4_fpu_arbiter #(
        .DATA_W     (DW),
        .EXP_SZ_W   (4),
        .N_REQ      (NR),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   last_done_cyc = 0;
    int   last_ack_cyc = 0;
    int   last_resp_cyc = -1;
    bit   b2b = 1'b0;
    bit   stub_hang = 1'b0;
    bit   inj_ovf = 1'b0;
    bit   inj_unf = 1'b0;
    bit   late_done = 1'b0;
    int   st_cnt = 0;
    int   rearm_cnt [NR];
    int   ack_q [$];
    exp_t resp_q [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    function automatic logic [31:0] onehot(input int i);
        logic [31:0] v;
        v = 32'd1;
        return v << i;
    endfunction

    always @(posedge clk) cyc++;

    // FPU stub
    always @(posedge clk) begin
        if (!bus.fpu_start) st_cnt <= 0;
        else st_cnt <= st_cnt + 1;
        bus.fpu_done        <= (bus.fpu_start && st_cnt == 5 && !stub_hang) || late_done;
        bus.fpu_div_by_zero <= bus.fpu_start && st_cnt == 5 && !stub_hang && bus.fpu_op == 2'b10;
        bus.fpu_overflow    <= bus.fpu_start && inj_ovf && st_cnt == 2;
        bus.fpu_underflow   <= bus.fpu_start && inj_unf && st_cnt == 3;
        bus.fpu_o           <= bus.fpu_done ? bus.fpu_a + bus.fpu_b : 32'hDEAD_BEEF;
    end

    // Monitor: pops the scoreboard whenever the DUT acks or responds
    always @(negedge clk) begin
        if (bus.fpu_done) last_done_cyc = cyc;
        if (|bus.ack) begin
            if (ack_q.size() == 0) begin
                check("unexpected_ack", 32'(bus.ack), 32'd0);
            end else begin
                int e;
                e = ack_q.pop_front();
                check("ack_grant", 32'(bus.ack), onehot(e));
                if (b2b && last_resp_cyc >= 0) check("b2b_gap", cyc - last_resp_cyc, 32'd1);
                last_ack_cyc = cyc;
            end
        end
        if (|bus.resp_valid) begin
            if (resp_q.size() == 0) begin
                check("unexpected_resp", 32'(bus.resp_valid), 32'd0);
            end else begin
                exp_t e;
                e = resp_q.pop_front();
                check("resp_onehot", 32'(bus.resp_valid), onehot(e.idx));
                check("resp_result", bus.result, e.res);
                check("resp_flags", 32'(bus.flags), 32'(e.flg));
                if (!stub_hang) check("resp_latency", cyc - last_done_cyc, 32'd3);
                else check("timeout_latency", cyc - last_ack_cyc, TO + 1);
            end
            last_resp_cyc = cyc;
        end
    end

    // One cycle; requesters drop req on their ack unless re-armed
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            if (bus.ack[i]) begin
                if (rearm_cnt[i] > 0) rearm_cnt[i]--;
                else bus.req[i] = 1'b0;
            end
        end
    endtask

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op);
        bus.a_in[i*DW +: DW]             = a;
        bus.b_in[i*DW +: DW]             = b;
        bus.op_in[i*OPCODE_W +: OPCODE_W] = op;
        bus.req[i]                       = 1'b1;
    endtask

    task automatic expect_op(input int i, input logic [31:0] res, input logic [3:0] flg);
        exp_t e;
        e.idx = i;
        e.res = res;
        e.flg = flg;
        ack_q.push_back(i);
        resp_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while ((resp_q.size() != 0 || ack_q.size() != 0 || bus.busy || bus.req != '0) && n < 300) begin
            tick();
            n++;
        end
        check("drain_budget", 32'(n < 300), 32'd1);
        tick();
    endtask

    task automatic do_reset();
        bus.req = '0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < NR; i++) rearm_cnt[i] = 0;
        bus.req   = '0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        bus.op_in = '0;
        do_reset();

        // reset state
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_fpu_start", 32'(bus.fpu_start), 32'd0);
        check("rst_fpu_a", bus.fpu_a, 32'd0);
        check("rst_fpu_b", bus.fpu_b, 32'd0);
        check("rst_fpu_op", 32'(bus.fpu_op), 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_flags", 32'(bus.flags), 32'd0);

        // single op: 3 + 4
        while (cyc < 10) tick();
        expect_op(0, 32'd7, 4'b0000);
        issue(0, 32'd3, 32'd4, 2'b00);
        tick();
        check("single_ack_t1", 32'(bus.ack), 32'd1);
        check("single_start", 32'(bus.fpu_start), 32'd1);
        check("single_fpu_a", bus.fpu_a, 32'd3);
        check("single_fpu_b", bus.fpu_b, 32'd4);
        check("single_busy", 32'(bus.busy), 32'd1);
        drain();

        // all four requesting, each held for two services
        do_reset();
        for (int r = 0; r < 2; r++) begin
            expect_op(0, 32'd101, 4'b0000);
            expect_op(1, 32'd112, 4'b0000);
            expect_op(2, 32'd123, 4'b0000);
            expect_op(3, 32'd134, 4'b0000);
        end
        for (int i = 0; i < NR; i++) rearm_cnt[i] = 1;
        issue(0, 32'd1, 32'd100, 2'b00);
        issue(1, 32'd11, 32'd101, 2'b01);
        issue(2, 32'd21, 32'd102, 2'b11);
        issue(3, 32'd31, 32'd103, 2'b00);
        drain();

        // lone requester served back to back
        do_reset();
        b2b = 1'b1;
        last_resp_cyc = -1;
        rearm_cnt[2] = 2;
        for (int r = 0; r < 3; r++) expect_op(2, 32'd50, 4'b0000);
        issue(2, 32'd20, 32'd30, 2'b00);
        drain();
        b2b = 1'b0;

        // sticky flags: set for their own response only
        do_reset();
        inj_ovf = 1'b1;
        expect_op(1, 32'd42, 4'b0001);
        issue(1, 32'd20, 32'd22, 2'b00);
        drain();
        inj_ovf = 1'b0;
        expect_op(2, 32'd2, 4'b0000);
        issue(2, 32'd1, 32'd1, 2'b01);
        drain();
        expect_op(3, 32'd8, 4'b0100);
        issue(3, 32'd8, 32'd0, 2'b10);
        drain();
        expect_op(0, 32'd10, 4'b0000);
        issue(0, 32'd5, 32'd5, 2'b00);
        drain();
        inj_unf = 1'b1;
        expect_op(1, 32'd13, 4'b0010);
        issue(1, 32'd6, 32'd7, 2'b11);
        drain();
        inj_unf = 1'b0;

        // reset in RUN abandons the op and restarts arbitration at 0
        do_reset();
        expect_op(0, 32'd11, 4'b0000);
        issue(0, 32'd5, 32'd6, 2'b00);
        drain();
        ack_q.push_back(1);
        issue(1, 32'd7, 32'd8, 2'b00);
        n = 0;
        while (!bus.ack[1] && n < 20) begin tick(); n++; end
        check("rst_run_ack_seen", 32'(n < 20), 32'd1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rst_run_start", 32'(bus.fpu_start), 32'd0);
        check("rst_run_busy", 32'(bus.busy), 32'd0);
        check("rst_run_fpu_a", bus.fpu_a, 32'd0);
        rst = 1'b0;
        late_done = 1'b1;
        tick();
        late_done = 1'b0;
        tick();
        check("late_done_busy", 32'(bus.busy), 32'd0);
        tick();
        check("late_done_busy2", 32'(bus.busy), 32'd0);
        expect_op(0, 32'd4, 4'b0000);
        expect_op(1, 32'd15, 4'b0000);
        issue(0, 32'd2, 32'd2, 2'b00);
        issue(1, 32'd7, 32'd8, 2'b00);
        drain();

        // FPU that never finishes
        do_reset();
        stub_hang = 1'b1;
`ifdef UNUM4_ARB_TIMEOUT_EN
        expect_op(2, 32'd0, 4'b1000);
        issue(2, 32'd9, 32'd9, 2'b00);
        drain();
        stub_hang = 1'b0;
        expect_op(0, 32'd3, 4'b0000);
        issue(0, 32'd1, 32'd2, 2'b00);
        drain();
`else
        ack_q.push_back(2);
        issue(2, 32'd9, 32'd9, 2'b00);
        repeat (60) tick();
        check("hang_busy", 32'(bus.busy), 32'd1);
        check("hang_start", 32'(bus.fpu_start), 32'd1);
        stub_hang = 1'b0;
        do_reset();
`endif

        check("ack_q_empty", 32'(ack_q.size()), 32'd0);
        check("resp_q_empty", 32'(resp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/unum4_fpu_arbiter.md
UNUM4_FPU_ARBITER -- requirements
Module: unum4_fpu_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_W, 32, operand/result width; EXP_SZ_W, 4, passed to shared constants only; N_REQ, 4, requester count (2..8); TIMEOUT_CYC, 255, watchdog limit.
REQ-002 clk  in  1  single clock; all logic on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 req  in  N_REQ  per-requester request, held until its ack.
REQ-005 a_in, b_in  in  N_REQ*DATA_W each  packed operands; slice i belongs to requester i.
REQ-006 op_in  in  N_REQ*OPCODE_W  packed opcodes: 00 add, 01 sub, 10 div, 11 mul.
REQ-007 ack  out  N_REQ  one-hot one-cycle pulse; the request is accepted.
REQ-008 resp_valid  out  N_REQ  one-hot one-cycle pulse; result and flags are valid.
REQ-009 result  out  DATA_W, plus flags  out  4: {timeout, div_by_zero, underflow, overflow}; both shared by all requesters.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 FPU side: fpu_start out 1; fpu_a, fpu_b out DATA_W; fpu_op out OPCODE_W; fpu_o in DATA_W; fpu_overflow, fpu_underflow, fpu_div_by_zero, fpu_done in 1.

Function
REQ-012 The FSM SHALL have the states IDLE, RUN, CAPT and RESP; the reset state is IDLE.
REQ-013 IDLE: with any req high, grant the first requester at or after (last_grant+1) mod N_REQ (round-robin); latch its a, b and op into fpu_a/b/op; pulse ack[g] on the next cycle; enter RUN.
REQ-014 RUN: hold fpu_start=1 and the operands stable; OR fpu_overflow/underflow/div_by_zero into flag registers every cycle; on fpu_done, drop fpu_start on the next cycle and enter CAPT.
REQ-015 CAPT: register fpu_o into result, because the FPU result settles one cycle after done; enter RESP.
REQ-016 RESP: pulse resp_valid[g] for exactly one cycle with result and flags stable; update last_grant=g; enter IDLE.
REQ-017 fpu_start SHALL be low for at least 2 cycles (CAPT, RESP) between operations.
REQ-018 Latency from a req sampled in IDLE at cycle t: ack at t+1, fpu_start high from t+1, resp_valid at D+3, where D is the cycle fpu_done is first seen.
REQ-019 Requests arriving while busy SHALL wait; a req reasserted during the RESP cycle SHALL be arbitrated in the following IDLE.
REQ-020 When only one requester is active it SHALL be granted back-to-back with no starvation penalty; when N_REQ requesters are active, each SHALL be served once per N_REQ operations.
REQ-021 Flag registers SHALL clear on entry to RUN; result SHALL hold its value until the next CAPT.

Reset
REQ-022 On rst: state IDLE, last_grant=N_REQ-1 (requester 0 first), ack=0, resp_valid=0, fpu_start=0, fpu_a/b/op=0, result=0, flags=0, busy=0, watchdog=0.
REQ-023 rst during RUN SHALL abandon the operation with no resp_valid; a late fpu_done SHALL be ignored in IDLE.

Configuration
REQ-024 Macro UNUM4_ARB_TIMEOUT_EN: when defined, a watchdog counts RUN cycles; at TIMEOUT_CYC without fpu_done, drop fpu_start, set result=0 and flags[3]=1, and go to RESP.
REQ-025 Without UNUM4_ARB_TIMEOUT_EN: no counter is built, flags[3] is tied to 0, and RUN waits indefinitely.

Structure
REQ-026 The shared package/header SHALL hold OPCODE_W, the opcode encodings, the FSM state encodings and the flag bit indices.
REQ-027 The round-robin priority picker SHALL be one sub-module, unum4_rr_pick (req, last_grant -> one-hot grant, valid), which is purely combinational.

Verification
REQ-028 The bench SHALL use a behavioural FPU stub with done 6 cycles after start and o=a+b, valid the cycle after done.
REQ-029 Single op: req[0], a=3, b=4, op=00 at t=10 -> ack[0] at t=11; resp_valid[0] with result=7, flags=0 at D+3.
REQ-030 All four req high together -> grants in order 0,1,2,3; then requester 0 again when all remain high.
REQ-031 Stub pulses overflow mid-RUN, and div_by_zero on an op=10 request -> the matching flags bit is set in that response only and cleared for the next.
REQ-032 rst asserted 3 cycles into RUN -> no resp_valid, fpu_start=0 the next cycle, the next request goes to requester 0.
REQ-033 UNUM4_ARB_TIMEOUT_EN, TIMEOUT_CYC=20, stub never asserts done -> resp_valid with result=0, flags=4'b1000 about 22 cycles after ack; without the macro, busy stays high.
